// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, per-round shift schedule,
// controller state encoding and 28-bit half rotation helpers.
package des_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Entries are 1-based DES bit numbers, matching the published tables.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [0:55] pc1(input logic [0:63] key);
        logic [0:55] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[i] = key[PC1_TABLE[i] - 1];
        end
        return r;
    endfunction

    function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[1:27], x[0]};
            2'd2:    return {x[2:27], x[0:1]};
            default: return x;
        endcase
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[27], x[0:26]};
            2'd2:    return {x[26:27], x[0:25]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_key_pc2.sv
// Combinational PC-2 selection: 56-bit C||D to 48-bit round key, bit 0 = DES bit 1.
module des_key_pc2
    import des_pkg::*;
(
    input  logic [0:55] cd,
    output logic [0:47] round_key
);

    always_comb begin
        round_key = '0;
        for (int i = 0; i < 48; i++) begin
            round_key[i] = cd[PC2_TABLE[i] - 1];
        end
    end

endmodule

// File: rtl/des_key_scheduler.sv
// DES round-key sequencer with valid/ready hand-off; K1..K16 or K16..K1.
// Optional key parity flag is built only when DES_KEY_PARITY_CHECK_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | waiting for start_strobe_din, C/D hold last value
//   ST_LOAD  | apply first-round rotation, register K1 (or K16)
//   ST_ISSUE | round key valid; each transfer rotates C/D for the next key
module des_key_scheduler
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_strobe_din,
    input  logic [0:63] key_din,
    input  logic        decrypt_din,
    input  logic        round_key_ready_din,
    output logic [0:47] round_key_dout,
    output logic        round_key_valid_dout,
    output logic [3:0]  round_index_dout,
    output logic        busy_dout,
    output logic        done_dout,
    output logic        parity_error_dout
);

    logic [1:0]  state;
    logic [0:55] cd;
    logic [0:55] cd_next;
    logic [0:47] pc2_out;
    logic        decrypt_q;
    logic        accept;
    logic        transfer;
    logic        last_transfer;
    logic [1:0]  amount;
    logic [3:0]  sched_idx;

    assign accept        = (state == ST_IDLE) && start_strobe_din;
    assign transfer      = (state == ST_ISSUE) && round_key_ready_din;
    assign last_transfer = transfer && (round_index_dout == 4'd15);

    // Decrypt walks the schedule backwards and rotates right, so the rotation
    // needed after transfer n comes from the mirrored schedule slot.
    always_comb begin
        amount    = 2'd0;
        sched_idx = decrypt_q ? (4'd15 - round_index_dout) : (round_index_dout + 4'd1);
        if (state == ST_LOAD) begin
            amount = decrypt_q ? 2'd0 : SHIFT_SCHED[0];
        end else if (transfer && !last_transfer) begin
            amount = SHIFT_SCHED[sched_idx];
        end
        if (decrypt_q) begin
            cd_next = {rotr28(cd[0:27], amount), rotr28(cd[28:55], amount)};
        end else begin
            cd_next = {rotl28(cd[0:27], amount), rotl28(cd[28:55], amount)};
        end
    end

    des_key_pc2 u_pc2 (
        .cd        (cd_next),
        .round_key (pc2_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            cd               <= '0;
            decrypt_q        <= 1'b0;
            round_index_dout <= 4'd0;
            round_key_dout   <= '0;
            done_dout        <= 1'b0;
        end else begin
            done_dout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cd        <= pc1(key_din);
                        decrypt_q <= decrypt_din;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cd             <= cd_next;
                    round_key_dout <= pc2_out;
                    state          <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (transfer) begin
                        round_index_dout <= round_index_dout + 4'd1;
                        if (last_transfer) begin
                            state     <= ST_IDLE;
                            done_dout <= 1'b1;
                        end else begin
                            cd             <= cd_next;
                            round_key_dout <= pc2_out;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign round_key_valid_dout = (state == ST_ISSUE);
    assign busy_dout            = (state != ST_IDLE);

`ifdef DES_KEY_PARITY_CHECK_EN
    logic even_byte;

    // DES key bytes carry odd parity; any even byte flags the key.
    always_comb begin
        even_byte = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (!(^key_din[8*b +: 8])) even_byte = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error_dout <= 1'b0;
        end else if (accept) begin
            parity_error_dout <= even_byte;
        end
    end
`else
    assign parity_error_dout = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: known-answer table, backpressure,
// reset abort, start-while-busy and random keys against a cumulative-shift model.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_strobe_din;
    logic [63:0] key_din;
    logic        decrypt_din;
    logic        round_key_ready_din;
    logic [47:0] round_key_dout;
    logic        round_key_valid_dout;
    logic [3:0]  round_index_dout;
    logic        busy_dout;
    logic        done_dout;
    logic        parity_error_dout;

    int vectors = 0;
    int miscompares = 0;

    des_key_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .start_strobe_din     (start_strobe_din),
        .key_din              (key_din),
        .decrypt_din          (decrypt_din),
        .round_key_ready_din  (round_key_ready_din),
        .round_key_dout       (round_key_dout),
        .round_key_valid_dout (round_key_valid_dout),
        .round_index_dout     (round_index_dout),
        .busy_dout            (busy_dout),
        .done_dout            (done_dout),
        .parity_error_dout    (parity_error_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                       16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                       44,49,39,56,34,53, 46,42,50,36,29,32};
    int sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_keys [16];
    logic [47:0] got_first;
    logic [47:0] got_last;

    // Reference: round r key = PC-2 of PC-1 halves rotated left by the running shift total.
    function automatic void build_model(input logic [63:0] key, input logic dec);
        bit          cd0 [56];
        bit          cds [56];
        int          tot;
        logic [47:0] k;
        tot = 0;
        for (int i = 0; i < 56; i++) cd0[i] = key[64 - pc1_t[i]];
        for (int r = 0; r < 16; r++) begin
            tot = tot + sched[r];
            for (int i = 0; i < 28; i++) begin
                cds[i]      = cd0[(i + tot) % 28];
                cds[28 + i] = cd0[28 + ((i + tot) % 28)];
            end
            for (int j = 0; j < 48; j++) k[47 - j] = cds[pc2_t[j] - 1];
            if (dec) exp_keys[15 - r] = k;
            else     exp_keys[r] = k;
        end
    endfunction

    function automatic logic exp_parity(input logic [63:0] k);
`ifdef DES_KEY_PARITY_CHECK_EN
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_key"},    {16'h0, round_key_dout}, 64'h0);
        chk({tag, "_valid"},  {63'h0, round_key_valid_dout}, 64'h0);
        chk({tag, "_index"},  {60'h0, round_index_dout}, 64'h0);
        chk({tag, "_busy"},   {63'h0, busy_dout}, 64'h0);
        chk({tag, "_done"},   {63'h0, done_dout}, 64'h0);
        chk({tag, "_parity"}, {63'h0, parity_error_dout}, 64'h0);
    endtask

    // Called at a negedge; leaves at the negedge of the done cycle (or after a reset abort).
    // mode: 0 ready=1, 1 random ready, 2 stall 3 cycles at index 5,
    //       3 start pulse while busy at index 3, 4 reset at index 8.
    task automatic run_seq(input logic [63:0] key, input logic dec, input int mode);
        int   n;
        int   cyc;
        int   stall;
        logic rdy;
        logic exp_par;
        build_model(key, dec);
        exp_par = exp_parity(key);
        start_strobe_din    = 1'b1;
        key_din             = key;
        decrypt_din         = dec;
        round_key_ready_din = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_strobe_din = 1'b0;
        key_din          = {$urandom, $urandom};
        decrypt_din      = ~dec;
        chk("load_busy",   {63'h0, busy_dout}, 64'h1);
        chk("load_valid",  {63'h0, round_key_valid_dout}, 64'h0);
        chk("load_done",   {63'h0, done_dout}, 64'h0);
        chk("load_parity", {63'h0, parity_error_dout}, {63'h0, exp_par});
        @(negedge clk);
        n = 0;
        cyc = 0;
        stall = 0;
        while (n < 16) begin
            if (cyc > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL seq_timeout: got %0d transfers required 16", n);
                break;
            end
            chk("valid", {63'h0, round_key_valid_dout}, 64'h1);
            chk("index", {60'h0, round_index_dout}, 64'(n));
            chk("key",   {16'h0, round_key_dout}, {16'h0, exp_keys[n]});
            chk("done_low", {63'h0, done_dout}, 64'h0);
            if (n == 0)  got_first = round_key_dout;
            if (n == 15) got_last  = round_key_dout;
            if (mode == 4 && n == 8) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_idle_zero("rst_abort");
                @(negedge clk);
                chk("rst_no_done", {63'h0, done_dout}, 64'h0);
                chk("rst_idle",    {63'h0, busy_dout}, 64'h0);
                return;
            end
            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    rdy = 1'b1;
                    if (n == 5 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end
                end
                default: rdy = 1'b1;
            endcase
            start_strobe_din = (mode == 3 && n == 3) || (n == 15 && rdy);
            if (start_strobe_din) begin
                key_din     = {$urandom, $urandom};
                decrypt_din = ~dec;
            end
            round_key_ready_din = rdy;
            if (rdy) n++;
            cyc++;
            @(negedge clk);
            start_strobe_din = 1'b0;
        end
        if (mode == 2) chk("stall_cycles", 64'(cyc), 64'd19);
        chk("end_valid",  {63'h0, round_key_valid_dout}, 64'h0);
        chk("end_done",   {63'h0, done_dout}, 64'h1);
        chk("end_index",  {60'h0, round_index_dout}, 64'h0);
        chk("end_busy",   {63'h0, busy_dout}, 64'h0);
        chk("end_parity", {63'h0, parity_error_dout}, {63'h0, exp_par});
    endtask

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [47:0] first;
        logic [47:0] last;
        int          mode;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0};
        tbl[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 0};
        tbl[2] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 2};
        tbl[3] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 3};
        tbl[4] = '{64'h133457799BBCDFF0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0};
        tbl[5] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 1};

        reset               = 1'b1;
        start_strobe_din    = 1'b0;
        key_din             = 64'h0;
        decrypt_din         = 1'b0;
        round_key_ready_din = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_idle_zero("reset");

        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].key, tbl[i].dec, tbl[i].mode);
            chk("tbl_first", {16'h0, got_first}, {16'h0, tbl[i].first});
            chk("tbl_last",  {16'h0, got_last},  {16'h0, tbl[i].last});
        end

        run_seq(64'h133457799BBCDFF1, 1'b0, 4);
        run_seq(64'h133457799BBCDFF1, 1'b0, 0);
        chk("restart_first", {16'h0, got_first}, 64'h1B02EFFC7072);

        for (int i = 0; i < 8; i++) begin
            run_seq({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
        end

        @(negedge clk);
        chk("final_done", {63'h0, done_dout}, 64'h0);
        chk("final_busy", {63'h0, busy_dout}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed by DES.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start_strobe_din  input  1  one-cycle request to load a new key and begin a 16-key sequence.
REQ-005 key_din  input  [0:63]  64-bit DES key, bit 0 = DES bit 1 (MSB); sampled only on an accepted start.
REQ-006 decrypt_din  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled only on an accepted start.
REQ-007 round_key_ready_din  input  1  consumer (expansion/key-XOR stage feeding the S-boxes) can take the current round key.
REQ-008 round_key_dout  output  [0:47]  current 48-bit round key, PC-2 applied, bit 0 = DES bit 1.
REQ-009 round_key_valid_dout  output  1  round_key_dout is valid.
REQ-010 round_index_dout  output  [3:0]  number of keys already transferred in this sequence (0..15).
REQ-011 busy_dout  output  1  a sequence is in progress.
REQ-012 done_dout  output  1  one-cycle pulse after the 16th transfer.
REQ-013 parity_error_dout  output  1  key parity flag (see Configuration).

Function
REQ-014 States SHALL be IDLE, LOAD, ISSUE; IDLE->LOAD on start_strobe_din, LOAD->ISSUE unconditionally, ISSUE->IDLE after the 16th transfer.
REQ-015 In IDLE, start_strobe_din SHALL latch PC-1(key_din) into 28-bit registers C and D and latch decrypt_din; start while busy_dout=1 SHALL be ignored.
REQ-016 In LOAD, C/D SHALL rotate by the first-round amount: encrypt left 1; decrypt 0.
REQ-017 round_key_valid_dout SHALL be 1 exactly in ISSUE, first asserted 2 cycles after the accepted start; round_key_dout = PC-2(C,D) registered, stable while valid=1 and ready=0.
REQ-018 A transfer SHALL occur on a cycle with valid=1 and ready=1; it increments round_index_dout and rotates C/D for the next key.
REQ-019 Rotation after transfer n (n=1..15) SHALL be: encrypt left by schedule[n+1]; decrypt right by schedule[17-n]; schedule[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 C and D SHALL rotate independently, 28-bit wrap-around.
REQ-021 On the 16th transfer: valid drops next cycle, done_dout pulses that cycle, round_index_dout returns to 0, state IDLE.
REQ-022 start_strobe_din in the same cycle as the 16th transfer SHALL be ignored; a start is accepted no earlier than the done_dout cycle.
REQ-023 busy_dout SHALL be 1 in LOAD and ISSUE, 0 in IDLE.

Reset
REQ-024 reset SHALL override all inputs and return the block to IDLE from any state, including mid-sequence, aborting without done_dout.
REQ-025 Reset values: round_key_dout=0, round_key_valid_dout=0, round_index_dout=0, busy_dout=0, done_dout=0, parity_error_dout=0, C=D=0.

Configuration
REQ-026 Macro DES_KEY_PARITY_CHECK_EN: when defined, on an accepted start parity_error_dout SHALL be registered to 1 if any key_din byte has even parity, held until the next accepted start or reset; the sequence runs regardless.
REQ-027 Without DES_KEY_PARITY_CHECK_EN, parity_error_dout SHALL be constant 0 and no parity logic synthesized.

Structure
REQ-028 Package des_pkg SHALL hold the PC-1 and PC-2 tables, the 16-entry shift schedule, and the state encoding constants.
REQ-029 PC-2 selection SHALL be a combinational sub-module des_key_pc2 (56 in, 48 out).

Verification
REQ-030 Encrypt: key 0x133457799BBCDFF1, decrypt=0, ready=1 -> first key 0x1B02EFFC7072, 16th key 0xCB3D8B0E17F5, done_dout on cycle after 16th transfer.
REQ-031 Decrypt: same key, decrypt=1 -> first key 0xCB3D8B0E17F5, last key 0x1B02EFFC7072; all 16 equal encrypt sequence reversed.
REQ-032 Backpressure: ready low 3 cycles at index 5 -> round_key_dout and round_index_dout=5 held, valid=1; exactly 16 transfers total.
REQ-033 Reset asserted at index 8 -> next cycle all outputs 0, IDLE, no done; new start restarts at K1.
REQ-034 Start while busy at index 3 -> ignored, sequence unchanged.
REQ-035 With DES_KEY_PARITY_CHECK_EN: key 0x133457799BBCDFF1 -> parity_error_dout=0; key 0x133457799BBCDFF0 -> 1; without macro both -> 0.
